// File: rtl/router_fifo.sv
// router_fifo: one destination-port output FIFO of the 1x3 router, tagging each byte as header/non-header.
// Latency: data_out is registered and valid one cycle after the read edge; full/empty are combinational from the pointers.
// Backpressure: writes while full and reads while empty are silently ignored; soft_reset flushes and overrides both.
//
// Ports:
//   clock       system clock, rising edge
//   resetn      asynchronous active-low reset (pointers, packet count, data_out)
//   soft_reset  synchronous flush from the synchronizer timeout, wins over read/write
//   write_enb   write request (this port's one-hot bit from the synchronizer)
//   read_enb    read request from the downstream consumer
//   lfd_state   marks the byte being written as the packet header
//   data_in     byte to store
//   data_out    registered read data, blanked to 0 between packets
//   full        no free entry
//   empty       no stored entry
//
// DEPTH must be a power of two (>= 4). The header length field is byte[7:2],
// so WIDTH must be at least 8.

module router_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             soft_reset,
   input  logic             write_enb,
   input  logic             read_enb,
   input  logic             lfd_state,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   // Each entry holds {header_flag, byte}.
   logic [WIDTH:0]   mem [DEPTH];

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   // when the lower bits match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // Bytes still to be delivered in the current packet (payload + parity).
   logic [6:0]       pkt_cnt;

   logic             do_write;
   logic             do_read;
   logic [WIDTH:0]   rd_entry;
   logic [6:0]       hdr_cnt;
   logic [6:0]       dec_cnt;

   // ------------------------------------------------------------------
   // Status flags
   // ------------------------------------------------------------------
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // Flush beats everything; full/empty are sampled before this edge's update,
   // so a read+write at full drops the write and a read+write at empty drops the read.
   assign do_write = write_enb & ~full  & ~soft_reset;
   assign do_read  = read_enb  & ~empty & ~soft_reset;

   assign rd_entry = mem[rd_ptr[AW-1:0]];

   // Header byte carries payload length in [7:2]; +1 accounts for the parity byte.
   assign hdr_cnt = {1'b0, rd_entry[7:2]} + 7'd1;
   assign dec_cnt = (pkt_cnt == 7'd0) ? 7'd0 : (pkt_cnt - 7'd1);

   // ------------------------------------------------------------------
   // Storage: no reset, contents are meaningless until written.
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (do_write) begin
         mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
      end
   end

   // ------------------------------------------------------------------
   // Pointers
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (soft_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_read) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read data and packet tracking
   // ------------------------------------------------------------------
   // data_out holds through mid-packet stalls and only blanks once the
   // current packet has been fully delivered (pkt_cnt == 0).
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         data_out <= '0;
         pkt_cnt  <= '0;
      end else if (soft_reset) begin
         data_out <= '0;
         pkt_cnt  <= '0;
      end else if (do_read) begin
         data_out <= rd_entry[WIDTH-1:0];
         pkt_cnt  <= rd_entry[WIDTH] ? hdr_cnt : dec_cnt;
      end else if (pkt_cnt == 7'd0) begin
         data_out <= '0;
      end
   end

endmodule

// File: tb/tb_router_fifo.sv
// tb_router_fifo: randomized and directed checks of router_fifo against a queue-based model.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: the model refuses writes at DEPTH entries and reads at zero entries.

module tb_router_fifo;

   localparam int DEPTH = 16;
   localparam int WIDTH = 8;

   logic             clock;
   logic             resetn;
   logic             soft_reset;
   logic             write_enb;
   logic             read_enb;
   logic             lfd_state;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             full;
   logic             empty;

   int passed = 0;
   int total  = 0;

   // Reference model: a queue of {header_flag, byte} plus expected data_out / packet count.
   logic [8:0] mq[$];
   int         m_pkt;
   logic [7:0] m_dout;

   router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .soft_reset (soft_reset),
      .write_enb  (write_enb),
      .read_enb   (read_enb),
      .lfd_state  (lfd_state),
      .data_in    (data_in),
      .data_out   (data_out),
      .full       (full),
      .empty      (empty)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic model_clear();
      mq.delete();
      m_pkt  = 0;
      m_dout = 8'h00;
   endtask

   // Drive one cycle at the falling edge, update the model with the spec's rules,
   // and return 1 unit after the rising edge so the caller can sample.
   task automatic step(input logic we, input logic re, input logic lfd,
                       input logic [7:0] din, input logic sr);
      logic [8:0] e;
      bit rd_ok, wr_ok;
      @(negedge clock);
      write_enb  = we;
      read_enb   = re;
      lfd_state  = lfd;
      data_in    = din;
      soft_reset = sr;
      if (sr) begin
         model_clear();
      end else begin
         rd_ok = re && (mq.size() > 0);
         wr_ok = we && (mq.size() < DEPTH);
         if (rd_ok) begin
            e = mq.pop_front();
            m_dout = e[7:0];
            if (e[8]) m_pkt = int'(e[7:2]) + 1;
            else if (m_pkt > 0) m_pkt = m_pkt - 1;
         end else if (m_pkt == 0) begin
            m_dout = 8'h00;
         end
         if (wr_ok) mq.push_back({lfd, din});
      end
      @(posedge clock);
      #1;
      write_enb  = 1'b0;
      read_enb   = 1'b0;
      lfd_state  = 1'b0;
      soft_reset = 1'b0;
   endtask

   task automatic test_reset();
      // Power-on state after release
      total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else passed++;
      total++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else passed++;
      total++; if (data_out !== 8'h00) $display("FAIL reset_dout: got %h expected 00", data_out); else passed++;

      // Put something visible on data_out and leave an entry stored
      step(1, 0, 1, 8'h10, 0);   // header, len 4 -> pkt 5
      step(1, 1, 0, 8'h77, 0);   // read header, store payload
      total++; if (data_out !== 8'h10) $display("FAIL pre_reset_dout: got %h expected 10", data_out); else passed++;

      // Asynchronous reset between edges
      #2;
      resetn = 1'b0;
      #1;
      model_clear();
      total++; if (empty !== 1'b1) $display("FAIL async_empty: got %b expected 1", empty); else passed++;
      total++; if (full !== 1'b0) $display("FAIL async_full: got %b expected 0", full); else passed++;
      total++; if (data_out !== 8'h00) $display("FAIL async_dout: got %h expected 00", data_out); else passed++;
      @(negedge clock);
      resetn = 1'b1;

      // Idle reads on an empty FIFO keep data_out blank
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 8'h00, 0);
         total++; if (data_out !== 8'h00) $display("FAIL idle_read_dout[%0d]: got %h expected 00", i, data_out); else passed++;
         total++; if (empty !== 1'b1) $display("FAIL idle_read_empty[%0d]: got %b expected 1", i, empty); else passed++;
      end
   endtask

   task automatic test_single_packet();
      logic [7:0] pkt [5];
      pkt[0] = 8'h0D; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3; pkt[4] = 8'h5C;
      // Read held high throughout; first read is ignored because FIFO is empty
      step(1, 1, 1, pkt[0], 0);
      total++; if (data_out !== 8'h00) $display("FAIL sp_first_dout: got %h expected 00", data_out); else passed++;
      for (int i = 1; i < 5; i++) begin
         step(1, 1, 0, pkt[i], 0);
         total++; if (data_out !== pkt[i-1]) $display("FAIL sp_dout[%0d]: got %h expected %h", i-1, data_out, pkt[i-1]); else passed++;
      end
      step(0, 1, 0, 8'h00, 0);
      total++; if (data_out !== pkt[4]) $display("FAIL sp_dout[4]: got %h expected %h", data_out, pkt[4]); else passed++;
      total++; if (empty !== 1'b1) $display("FAIL sp_empty: got %b expected 1", empty); else passed++;
      step(0, 0, 0, 8'h00, 0);
      total++; if (data_out !== 8'h00) $display("FAIL sp_blank: got %h expected 00", data_out); else passed++;
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < DEPTH; i++) begin
         step(1, 0, 0, 8'(i), 0);
         if (i < DEPTH - 1) begin
            total++; if (full !== 1'b0) $display("FAIL fill_early_full[%0d]: got %b expected 0", i, full); else passed++;
         end
      end
      total++; if (full !== 1'b1) $display("FAIL fill_full: got %b expected 1", full); else passed++;
      step(1, 0, 0, 8'hFF, 0);
      total++; if (full !== 1'b1) $display("FAIL overflow_full: got %b expected 1", full); else passed++;
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 1, 0, 8'h00, 0);
         total++; if (data_out !== 8'(i)) $display("FAIL drain_dout[%0d]: got %h expected %h", i, data_out, 8'(i)); else passed++;
      end
      total++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b expected 1", empty); else passed++;
      step(0, 1, 0, 8'h00, 0);
      total++; if (data_out !== 8'h00) $display("FAIL drain_no_ff: got %h expected 00", data_out); else passed++;
   endtask

   task automatic test_concurrent();
      logic [7:0] oldest;
      oldest = 8'($urandom);
      step(1, 0, 0, oldest, 0);
      for (int i = 1; i < DEPTH; i++) step(1, 0, 0, 8'($urandom_range(0, 8'hED)), 0);
      total++; if (full !== 1'b1) $display("FAIL cf_full: got %b expected 1", full); else passed++;
      step(1, 1, 0, 8'hEE, 0);
      total++; if (data_out !== oldest) $display("FAIL cf_oldest: got %h expected %h", data_out, oldest); else passed++;
      total++; if (full !== 1'b0) $display("FAIL cf_full_drop: got %b expected 0", full); else passed++;
      // Drain: the refused 0xEE must never show up
      for (int i = 1; i < DEPTH; i++) begin
         step(0, 1, 0, 8'h00, 0);
         total++; if (data_out !== m_dout || data_out === 8'hEE) $display("FAIL cf_drain[%0d]: got %h expected %h", i, data_out, m_dout); else passed++;
      end
      total++; if (empty !== 1'b1) $display("FAIL cf_empty: got %b expected 1", empty); else passed++;

      // Read+write at empty: write lands, read ignored, blanking unaffected
      step(1, 1, 0, 8'h33, 0);
      total++; if (empty !== 1'b0) $display("FAIL ce_empty: got %b expected 0", empty); else passed++;
      total++; if (data_out !== 8'h00) $display("FAIL ce_dout: got %h expected 00", data_out); else passed++;
      step(0, 1, 0, 8'h00, 0);
      total++; if (data_out !== 8'h33) $display("FAIL ce_read: got %h expected 33", data_out); else passed++;
      step(0, 0, 0, 8'h00, 0);
      total++; if (data_out !== 8'h00) $display("FAIL ce_blank: got %h expected 00", data_out); else passed++;
   endtask

   task automatic test_soft_reset();
      step(1, 0, 1, 8'h24, 0);               // header: length 9 -> pkt 10
      for (int i = 1; i < 10; i++) step(1, 0, 0, 8'(8'hB0 + i), 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 0);
      total++; if (data_out !== 8'hB2) $display("FAIL sr_pre_dout: got %h expected b2", data_out); else passed++;
      step(1, 1, 0, 8'h99, 1);
      total++; if (empty !== 1'b1) $display("FAIL sr_empty: got %b expected 1", empty); else passed++;
      total++; if (full !== 1'b0) $display("FAIL sr_full: got %b expected 0", full); else passed++;
      total++; if (data_out !== 8'h00) $display("FAIL sr_dout: got %h expected 00", data_out); else passed++;
      // Packet count cleared: an idle cycle keeps data_out blank
      step(0, 0, 0, 8'h00, 0);
      total++; if (data_out !== 8'h00) $display("FAIL sr_idle: got %h expected 00", data_out); else passed++;
      // Fresh packet: header 0x08 -> length 2 -> pkt 3
      step(1, 0, 1, 8'h08, 0);
      step(0, 1, 0, 8'h00, 0);
      total++; if (data_out !== 8'h08) $display("FAIL sr_hdr: got %h expected 08", data_out); else passed++;
      // Mid-packet stall holds data_out
      step(0, 1, 0, 8'h00, 0);
      total++; if (data_out !== 8'h08) $display("FAIL sr_hold: got %h expected 08", data_out); else passed++;
      step(1, 0, 0, 8'hC1, 0);
      step(1, 1, 0, 8'hC2, 0);
      step(1, 1, 0, 8'hC3, 0);
      step(0, 1, 0, 8'h00, 0);
      total++; if (data_out !== 8'hC3) $display("FAIL sr_last: got %h expected c3", data_out); else passed++;
      step(0, 0, 0, 8'h00, 0);
      total++; if (data_out !== 8'h00) $display("FAIL sr_end_blank: got %h expected 00", data_out); else passed++;
   endtask

   task automatic test_wrap_stress();
      bit we, re, lfd;
      for (int i = 0; i < 8; i++) step(1, 0, 1'($urandom_range(0, 7) == 0), 8'($urandom), 0);
      for (int i = 0; i < 100; i++) begin
         we  = 1'($urandom);
         re  = 1'($urandom);
         lfd = 1'($urandom_range(0, 7) == 0);
         if (mq.size() <= 1)  re = 1'b0;
         if (mq.size() >= 15) we = 1'b0;
         step(we, re, lfd, 8'($urandom), 0);
         total++; if (data_out !== m_dout) $display("FAIL ws_dout[%0d]: got %h expected %h", i, data_out, m_dout); else passed++;
         total++; if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) || (full && empty))
            $display("FAIL ws_flags[%0d]: got full=%b empty=%b expected full=%b empty=%b", i, full, empty, mq.size() == DEPTH, mq.size() == 0);
         else passed++;
      end
      // Drain what remains and confirm order
      while (mq.size() > 0) begin
         step(0, 1, 0, 8'h00, 0);
         total++; if (data_out !== m_dout) $display("FAIL ws_drain: got %h expected %h", data_out, m_dout); else passed++;
      end
      total++; if (empty !== 1'b1) $display("FAIL ws_empty: got %b expected 1", empty); else passed++;
   endtask

   initial begin
      resetn     = 1'b0;
      soft_reset = 1'b0;
      write_enb  = 1'b0;
      read_enb   = 1'b0;
      lfd_state  = 1'b0;
      data_in    = '0;
      model_clear();
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      #1;

      test_reset();
      test_single_packet();
      test_fill_overflow();
      test_concurrent();
      test_soft_reset();
      test_wrap_stress();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
